// File: rtl/lsu.sv
// Load/store unit: one memory op per request through IDLE -> REQ -> RESP, with
// byte-lane placement for stores, sign/zero extension for loads and misalignment flagging.
module lsu #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [2:0]        in_func3,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_err,
  output logic [DATA_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [DATA_W-1:0] PMEM_BASE = DATA_W'(64'h0000_0000_8000_0000);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_addr, r_wdata, r_rdata;
  logic [2:0]        r_func3;
  logic              r_is_load, r_is_store, r_err;
  logic [4:0]        r_rd;

  logic [2:0]        w_off;
  logic              w_mis, w_wen;
  logic [7:0]        w_mask_base;
  logic [DATA_W-1:0] w_ld_raw, w_result;

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [2:0] f3);
    case (f3)
      3'b000:  load_extend = {{(DATA_W-8){raw[7]}},   raw[7:0]};
      3'b001:  load_extend = {{(DATA_W-16){raw[15]}}, raw[15:0]};
      3'b010:  load_extend = {{(DATA_W-32){raw[31]}}, raw[31:0]};
      3'b100:  load_extend = {{(DATA_W-8){1'b0}},     raw[7:0]};
      3'b101:  load_extend = {{(DATA_W-16){1'b0}},    raw[15:0]};
      3'b110:  load_extend = {{(DATA_W-32){1'b0}},    raw[31:0]};
      default: load_extend = raw;
    endcase
  endfunction

  assign w_off     = r_addr[2:0];
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_RESP);
  assign out_rdata = r_rdata;
  assign out_rd    = r_rd;
  assign out_err   = r_err;
  assign mem_raddr = {r_addr[DATA_W-1:3], 3'b000};
  assign mem_waddr = {r_addr[DATA_W-1:3], 3'b000};
  assign mem_wdata = r_wdata << {w_off, 3'b000};

  always_comb begin
    w_mis       = 1'b0;
    w_mask_base = 8'h01;
    case (r_func3[1:0])
      2'b00: begin w_mis = 1'b0;          w_mask_base = 8'h01; end
      2'b01: begin w_mis = r_addr[0];     w_mask_base = 8'h03; end
      2'b10: begin w_mis = |r_addr[1:0];  w_mask_base = 8'h0F; end
      default: begin w_mis = |r_addr[2:0]; w_mask_base = 8'hFF; end
    endcase
    w_mis = w_mis & (r_is_load | r_is_store);
  end

  // Write strobe drops immediately on rst so an aborted store never lands.
  assign w_wen     = (r_state == S_REQ) && r_is_store && !w_mis && !rst;
  assign mem_wen   = w_wen;
  assign mem_wmask = w_wen ? (w_mask_base << w_off) : 8'h00;

  assign w_ld_raw = mem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_result = '0;
    if (w_mis)           w_result = '0;
    else if (r_is_load)  w_result = load_extend(w_ld_raw, r_func3);
    else if (r_is_store) w_result = '0;
    else                 w_result = r_addr;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_RESP;
      S_RESP:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= PMEM_BASE;
      r_rdata    <= '0;
      r_rd       <= '0;
      r_err      <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // p0: request capture in IDLE
      if (r_state == S_IDLE && in_valid) begin
        r_addr     <= in_addr;
        r_wdata    <= in_wdata;
        r_func3    <= in_func3;
        r_is_load  <= in_is_load;
        r_is_store <= in_is_store;
        r_rd       <= in_rd;
      end
      // p1: result capture at end of REQ, held through RESP
      if (r_state == S_REQ) begin
        r_rdata <= w_result;
        r_err   <= w_mis;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: memory model behind the port, reference memory and
// an expected-result queue filled at issue and drained at the result handshake.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] in_addr, in_wdata;
  logic [2:0]  in_func3;
  logic        in_is_load, in_is_store;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [63:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_err;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        mem_wen;

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] tb_mem  [16];
  logic [63:0] ref_mem [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_func3(in_func3),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_rd(out_rd), .out_err(out_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  // Combinational-read memory covering 0x8000_0000..0x8000_007F.
  assign mem_rdata = tb_mem[mem_raddr[6:3]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 64'h0;
    end else if (mem_wen) begin
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b]) tb_mem[mem_waddr[6:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] word, input int off,
                                             input logic [2:0] f3);
    int          n;
    logic [63:0] r;
    n = 1 << f3[1:0];
    r = 64'h0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = word[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && r[8*n-1])
      for (int i = 8*n; i < 64; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = 64'h0;
  endtask

  // One complete transaction; hold = cycles to keep out_ready low in RESP.
  task automatic op(input string name, input logic [63:0] addr, input logic [63:0] wdata,
                    input logic [2:0] f3, input logic ld, input logic st,
                    input logic [4:0] rd, input int hold);
    logic [63:0] al, snap_rdata;
    logic [7:0]  exp_mask;
    logic        mis, exp_wen, snap_err;
    logic [4:0]  snap_rd;
    int          n, off, idx, w;
    exp_t        e;

    al  = {addr[63:3], 3'b000};
    off = int'(addr[2:0]);
    idx = int'(addr[6:3]);
    n   = 1 << f3[1:0];
    mis = (ld || st) && ((off % n) != 0);
    exp_wen  = st && !mis;
    exp_mask = 8'h00;
    if (exp_wen) for (int i = 0; i < n; i++) exp_mask[off+i] = 1'b1;
    e.rd  = rd;
    e.err = mis;
    if (mis)     e.rdata = 64'h0;
    else if (ld) e.rdata = model_load(ref_mem[idx], off, f3);
    else if (st) e.rdata = 64'h0;
    else         e.rdata = addr;

    @(negedge clk);
    chk({name, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_func3 = f3;
    in_is_load = ld; in_is_store = st; in_rd = rd;
    sb.push_back(e);

    @(negedge clk);
    // Junk store request while busy; it must be ignored.
    in_valid = 1'b1; in_addr = {32'h8000_0000, $urandom}; in_wdata = {$urandom, $urandom};
    in_func3 = 3'b011; in_is_load = 1'b0; in_is_store = 1'b1; in_rd = 5'd31;
    chk({name, "_req_in_ready"}, in_ready, 0);
    chk({name, "_req_out_valid"}, out_valid, 0);
    chk({name, "_waddr"}, mem_waddr, al);
    chk({name, "_raddr"}, mem_raddr, al);
    chk({name, "_wen"}, mem_wen, exp_wen);
    chk({name, "_wmask"}, mem_wmask, exp_mask);
    if (exp_wen) begin
      chk({name, "_wdata"}, mem_wdata, wdata << (8*off));
      for (int i = 0; i < n; i++) ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
    end

    @(negedge clk);
    w = 0;
    while (out_valid !== 1'b1 && w < 5) begin @(negedge clk); w++; end
    chk({name, "_resp_latency"}, w, 0);

    snap_rdata = out_rdata; snap_rd = out_rd; snap_err = out_err;
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_in_ready"}, in_ready, 0);
      chk({name, "_hold_wen"}, mem_wen, 0);
      chk({name, "_hold_rdata"}, out_rdata, snap_rdata);
      chk({name, "_hold_rd"}, out_rd, snap_rd);
      chk({name, "_hold_err"}, out_err, snap_err);
    end

    out_ready = 1'b1;
    e = sb.pop_front();
    chk({name, "_rdata"}, out_rdata, e.rdata);
    chk({name, "_rd"}, out_rd, e.rd);
    chk({name, "_err"}, out_err, e.err);

    @(negedge clk);
    chk({name, "_exit_in_ready"}, in_ready, 1);
    chk({name, "_exit_out_valid"}, out_valid, 0);
    chk({name, "_raddr_hold"}, mem_raddr, al);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_wdata = '0; in_func3 = '0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_rd = '0;
    clear_ref();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_raddr", mem_raddr, 64'h8000_0000);
    chk("rst_wen", mem_wen, 0);
    chk("rst_wmask", mem_wmask, 0);

    op("sd",   64'h8000_0010, 64'h1122_3344_5566_7788, 3'b011, 1'b0, 1'b1, 5'd5, 0);
    op("ld",   64'h8000_0010, 64'h0, 3'b011, 1'b1, 1'b0, 5'd6, 0);
    op("sb",   64'h8000_0013, 64'hAB, 3'b000, 1'b0, 1'b1, 5'd7, 0);
    op("lbu",  64'h8000_0013, 64'h0, 3'b100, 1'b1, 1'b0, 5'd8, 0);
    op("lb",   64'h8000_0013, 64'h0, 3'b000, 1'b1, 1'b0, 5'd9, 0);
    op("sw",   64'h8000_0000, 64'h8765_4321_80FF_0000, 3'b010, 1'b0, 1'b1, 5'd10, 0);
    op("lh",   64'h8000_0002, 64'h0, 3'b001, 1'b1, 1'b0, 5'd11, 0);
    op("lhu",  64'h8000_0002, 64'h0, 3'b101, 1'b1, 1'b0, 5'd12, 0);
    op("lw_mis", 64'h8000_0006, 64'h0, 3'b010, 1'b1, 1'b0, 5'd13, 0);
    op("sh_mis", 64'h8000_0011, 64'hFFFF, 3'b001, 1'b0, 1'b1, 5'd14, 0);
    op("sh",   64'h8000_0016, 64'hBEEF, 3'b001, 1'b0, 1'b1, 5'd15, 0);
    op("lwu",  64'h8000_0014, 64'h0, 3'b110, 1'b1, 1'b0, 5'd16, 0);
    op("lw",   64'h8000_0014, 64'h0, 3'b010, 1'b1, 1'b0, 5'd17, 0);
    op("f3_7", 64'h8000_0010, 64'h0, 3'b111, 1'b1, 1'b0, 5'd18, 0);
    op("pass", 64'h0000_0001_2345_6789, 64'hFFFF, 3'b010, 1'b0, 1'b0, 5'd19, 0);
    op("hold", 64'h8000_0002, 64'h0, 3'b001, 1'b1, 1'b0, 5'd20, 5);

    for (int i = 0; i < 16; i++) chk($sformatf("mem_%0d", i), tb_mem[i], ref_mem[i]);

    // Reset during REQ of a store aborts it.
    @(negedge clk);
    in_valid = 1'b1; in_addr = 64'h8000_0030; in_wdata = 64'hDEAD_BEEF;
    in_func3 = 3'b010; in_is_load = 1'b0; in_is_store = 1'b1; in_rd = 5'd21;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_req_wen_pre", mem_wen, 1);
    rst = 1'b1;
    #1;
    chk("abort_wen", mem_wen, 0);
    chk("abort_wmask", mem_wmask, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_ref();
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_raddr", mem_raddr, 64'h8000_0000);
    @(negedge clk);
    chk("abort_out_valid2", out_valid, 0);

    op("sd2", 64'h8000_0020, 64'hCAFE_F00D_0123_4567, 3'b011, 1'b0, 1'b1, 5'd22, 0);
    op("lb2", 64'h8000_0027, 64'h0, 3'b000, 1'b1, 1'b0, 5'd23, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("mem2_%0d", i), tb_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
